// File: rtl/uart_rx_sampler_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_sampler_if
// Brief    : Signal bundle between the RX control FSM / serial line and the
//            oversampling bit-recovery stage. The sampler takes the slave
//            modport, and its driver (FSM or bench) takes the master modport.
// Revision : 1.0 - initial release
// ============================================================================
interface uart_rx_sampler_if #(
  parameter int PRESCALE_W = 6,
  parameter int EDGE_W     = 5,
  parameter int BIT_W      = 4
);
  logic                  i_rx_in;
  logic [PRESCALE_W-1:0] i_prescale;
  logic                  i_edge_cnt_en;
  logic                  i_data_sample_en;
  logic [EDGE_W-1:0]     o_edge_cnt;
  logic [BIT_W-1:0]      o_bit_cnt;
  logic                  o_sampled_bit;
  logic                  o_sample_valid;
  logic                  o_cfg_err;

  modport master (
    output i_rx_in, i_prescale, i_edge_cnt_en, i_data_sample_en,
    input  o_edge_cnt, o_bit_cnt, o_sampled_bit, o_sample_valid, o_cfg_err
  );

  modport slave (
    input  i_rx_in, i_prescale, i_edge_cnt_en, i_data_sample_en,
    output o_edge_cnt, o_bit_cnt, o_sampled_bit, o_sample_valid, o_cfg_err
  );
endinterface
`default_nettype wire

// File: rtl/uart_rx_sampler.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_sampler
// Brief    : UART RX oversampling timing and bit recovery. Counts oversampling
//            edges inside a bit period and completed bit periods, and recovers
//            each bit with a 3-sample majority vote around the bit centre.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_sampler #(
  parameter int PRESCALE_W = 6,
  parameter int EDGE_W     = 5,
  parameter int BIT_W      = 4
) (
  input  wire logic         clk,
  input  wire logic         rst,
  uart_rx_sampler_if.slave  bus
);

  // Common compare width, one bit wider than either operand so that
  // prescale-1 and half-2 underflow to large values that never match.
  localparam int              c_CW     = ((PRESCALE_W > EDGE_W) ? PRESCALE_W : EDGE_W) + 1;
  localparam logic [c_CW-1:0] c_PS_MIN = c_CW'(4);
  localparam logic [c_CW-1:0] c_PS_MAX = c_CW'(2 ** EDGE_W);

  logic [EDGE_W-1:0] r_edge_cnt;
  logic [BIT_W-1:0]  r_bit_cnt;
  logic              r_sampled_bit;
  logic              r_sample_valid;
  logic              r_cfg_err;
  // First two centre samples; the third sample is the live rx_in in the
  // vote cycle, so it never needs to be stored.
  logic              r_s0;
  logic              r_s1;

  logic [c_CW-1:0]   w_ps;
  logic [c_CW-1:0]   w_ps_m1;
  logic [c_CW-1:0]   w_half;
  logic [c_CW-1:0]   w_edge;
  logic              w_cfg_bad;
  logic              w_run;
  logic              w_smp_en;
  logic              w_wrap;
  logic              w_cap0;
  logic              w_cap1;
  logic              w_vote;
  logic              w_majority;

  assign w_ps       = c_CW'(bus.i_prescale);
  assign w_ps_m1    = w_ps - c_CW'(1);
  assign w_half     = w_ps >> 1;
  assign w_edge     = c_CW'(r_edge_cnt);
  assign w_cfg_bad  = (w_ps < c_PS_MIN) | (w_ps > c_PS_MAX);

  // Counting is gated by the registered config error, not the live compare.
  assign w_run      = bus.i_edge_cnt_en & ~r_cfg_err;
  assign w_smp_en   = w_run & bus.i_data_sample_en;

  // >= rather than == so a prescale lowered mid-frame wraps next cycle.
  assign w_wrap     = (w_edge >= w_ps_m1);

  assign w_cap0     = w_smp_en & (w_edge == (w_half - c_CW'(2)));
  assign w_cap1     = w_smp_en & (w_edge == (w_half - c_CW'(1)));
  assign w_vote     = w_smp_en & (w_edge == w_half);
  assign w_majority = (r_s0 & r_s1) | (r_s0 & bus.i_rx_in) | (r_s1 & bus.i_rx_in);

  // Register the prescale range check.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cfg_err <= 1'b0;
    end else begin
      r_cfg_err <= w_cfg_bad;
    end
  end

  // Edge counter within a bit period and completed-bit counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_edge_cnt <= '0;
      r_bit_cnt  <= '0;
    end else if (!w_run) begin
      r_edge_cnt <= '0;
      r_bit_cnt  <= '0;
    end else if (w_wrap) begin
      r_edge_cnt <= '0;
      r_bit_cnt  <= r_bit_cnt + BIT_W'(1);
    end else begin
      r_edge_cnt <= r_edge_cnt + EDGE_W'(1);
    end
  end

  // Capture centre samples and emit the majority vote with a one-cycle valid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s0           <= 1'b1;
      r_s1           <= 1'b1;
      r_sampled_bit  <= 1'b1;
      r_sample_valid <= 1'b0;
    end else begin
      r_sample_valid <= w_vote;
      if (w_cap0) begin
        r_s0 <= bus.i_rx_in;
      end
      if (w_cap1) begin
        r_s1 <= bus.i_rx_in;
      end
      if (w_vote) begin
        r_sampled_bit <= w_majority;
      end
    end
  end

  assign bus.o_edge_cnt     = r_edge_cnt;
  assign bus.o_bit_cnt      = r_bit_cnt;
  assign bus.o_sampled_bit  = r_sampled_bit;
  assign bus.o_sample_valid = r_sample_valid;
  assign bus.o_cfg_err      = r_cfg_err;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_sampler.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_sampler
// Brief    : Directed self-checking bench for uart_rx_sampler.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_sampler;
  localparam int PRESCALE_W = 6;
  localparam int EDGE_W     = 5;
  localparam int BIT_W      = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  uart_rx_sampler_if #(.PRESCALE_W(PRESCALE_W), .EDGE_W(EDGE_W), .BIT_W(BIT_W)) bus ();

  uart_rx_sampler #(.PRESCALE_W(PRESCALE_W), .EDGE_W(EDGE_W), .BIT_W(BIT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs are then driven and outputs read 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.i_rx_in = 1'b1; bus.i_prescale = 6'd8;
    bus.i_edge_cnt_en = 1'b0; bus.i_data_sample_en = 1'b0;
    rst = 1'b0;
    repeat (3) tick();
    n_vec++; if (bus.o_edge_cnt !== 5'd0) begin n_err++; $display("FAIL reset_edge_cnt: got %0d expected 0", bus.o_edge_cnt); end
    n_vec++; if (bus.o_bit_cnt !== 4'd0) begin n_err++; $display("FAIL reset_bit_cnt: got %0d expected 0", bus.o_bit_cnt); end
    n_vec++; if (bus.o_sampled_bit !== 1'b1) begin n_err++; $display("FAIL reset_sampled_bit: got %b expected 1", bus.o_sampled_bit); end
    n_vec++; if (bus.o_sample_valid !== 1'b0) begin n_err++; $display("FAIL reset_sample_valid: got %b expected 0", bus.o_sample_valid); end
    n_vec++; if (bus.o_cfg_err !== 1'b0) begin n_err++; $display("FAIL reset_cfg_err: got %b expected 0", bus.o_cfg_err); end
    #2 rst = 1'b1;
    tick();
  endtask

  // Prescale 8, line low for 10 bit periods.
  task automatic test_count_p8();
    bus.i_prescale = 6'd8; bus.i_rx_in = 1'b0;
    bus.i_data_sample_en = 1'b1; bus.i_edge_cnt_en = 1'b0;
    tick();
    bus.i_edge_cnt_en = 1'b1;
    for (int k = 1; k <= 80; k++) begin
      tick();
      n_vec++;
      if (bus.o_edge_cnt !== 5'(k % 8) || bus.o_bit_cnt !== 4'(k / 8)) begin
        n_err++;
        $display("FAIL count_p8 k=%0d: got edge=%0d bit=%0d expected edge=%0d bit=%0d",
                 k, bus.o_edge_cnt, bus.o_bit_cnt, k % 8, k / 8);
      end
      n_vec++;
      if (bus.o_sample_valid !== ((k % 8) == 5)) begin
        n_err++;
        $display("FAIL count_p8_valid k=%0d: got %b expected %b", k, bus.o_sample_valid, ((k % 8) == 5));
      end
      if ((k % 8) == 5) begin
        n_vec++;
        if (bus.o_sampled_bit !== 1'b0) begin
          n_err++; $display("FAIL count_p8_bit k=%0d: got %b expected 0", k, bus.o_sampled_bit);
        end
      end
    end
    bus.i_edge_cnt_en = 1'b0;
    tick();
  endtask

  // Prescale 16, frame 0x5A LSB-first with start and stop bits.
  task automatic test_frame_p16();
    logic [9:0] frame;
    int         nvalid;
    int         e;
    int         b;
    frame  = {1'b1, 8'h5A, 1'b0};
    nvalid = 0;
    bus.i_prescale = 6'd16; bus.i_edge_cnt_en = 1'b0;
    bus.i_data_sample_en = 1'b1; bus.i_rx_in = 1'b1;
    tick();
    bus.i_edge_cnt_en = 1'b1; bus.i_rx_in = frame[0];
    for (int k = 1; k <= 160; k++) begin
      tick();
      e = k % 16;
      b = k / 16;
      bus.i_rx_in = (b < 10) ? frame[b] : 1'b1;
      if (bus.o_sample_valid === 1'b1) nvalid++;
      n_vec++;
      if (bus.o_sample_valid !== (e == 9)) begin
        n_err++; $display("FAIL frame_valid k=%0d: got %b expected %b", k, bus.o_sample_valid, (e == 9));
      end
      if (e == 9) begin
        n_vec++;
        if (bus.o_sampled_bit !== frame[b]) begin
          n_err++; $display("FAIL frame_bit%0d: got %b expected %b", b, bus.o_sampled_bit, frame[b]);
        end
      end
    end
    n_vec++;
    if (nvalid != 10) begin
      n_err++; $display("FAIL frame_valid_count: got %0d expected 10", nvalid);
    end
    bus.i_edge_cnt_en = 1'b0;
    tick();
  endtask

  // Prescale 32: single-clock glitch is voted out, two-clock glitch wins.
  task automatic test_glitch_p32();
    int e;
    bus.i_prescale = 6'd32; bus.i_edge_cnt_en = 1'b0;
    bus.i_data_sample_en = 1'b1; bus.i_rx_in = 1'b0;
    tick();
    bus.i_edge_cnt_en = 1'b1;
    for (int k = 1; k <= 63; k++) begin
      tick();
      e = k % 32;
      bus.i_rx_in = ((e == 15) || (k >= 32 && e == 16)) ? 1'b1 : 1'b0;
      if (k == 17 || k == 49) begin
        n_vec++;
        if (bus.o_sample_valid !== 1'b1) begin
          n_err++; $display("FAIL glitch_valid k=%0d: got %b expected 1", k, bus.o_sample_valid);
        end
        n_vec++;
        if (bus.o_sampled_bit !== (k == 49)) begin
          n_err++; $display("FAIL glitch_bit k=%0d: got %b expected %b", k, bus.o_sampled_bit, (k == 49));
        end
      end
    end
    bus.i_edge_cnt_en = 1'b0; bus.i_rx_in = 1'b1;
    tick();
  endtask

  // Drop edge_cnt_en mid-frame at edge 3 / bit 4, then restart.
  task automatic test_drop_en();
    bus.i_prescale = 6'd8; bus.i_edge_cnt_en = 1'b0;
    bus.i_data_sample_en = 1'b1; bus.i_rx_in = 1'b1;
    tick();
    bus.i_edge_cnt_en = 1'b1;
    repeat (35) tick();
    n_vec++;
    if (bus.o_edge_cnt !== 5'd3 || bus.o_bit_cnt !== 4'd4) begin
      n_err++; $display("FAIL drop_pre: got edge=%0d bit=%0d expected edge=3 bit=4", bus.o_edge_cnt, bus.o_bit_cnt);
    end
    bus.i_edge_cnt_en = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      n_vec++;
      if (bus.o_edge_cnt !== 5'd0 || bus.o_bit_cnt !== 4'd0 || bus.o_sample_valid !== 1'b0) begin
        n_err++; $display("FAIL drop_clear k=%0d: got edge=%0d bit=%0d valid=%b expected 0/0/0",
                          k, bus.o_edge_cnt, bus.o_bit_cnt, bus.o_sample_valid);
      end
    end
    bus.i_edge_cnt_en = 1'b1;
    tick();
    n_vec++;
    if (bus.o_edge_cnt !== 5'd1 || bus.o_bit_cnt !== 4'd0) begin
      n_err++; $display("FAIL drop_restart: got edge=%0d bit=%0d expected edge=1 bit=0", bus.o_edge_cnt, bus.o_bit_cnt);
    end
    repeat (7) tick();
    n_vec++;
    if (bus.o_edge_cnt !== 5'd0 || bus.o_bit_cnt !== 4'd1) begin
      n_err++; $display("FAIL drop_first_wrap: got edge=%0d bit=%0d expected edge=0 bit=1", bus.o_edge_cnt, bus.o_bit_cnt);
    end
    bus.i_edge_cnt_en = 1'b0;
    tick();
  endtask

  // data_sample_en falling in the vote cycle suppresses the vote.
  task automatic test_suppress();
    bus.i_prescale = 6'd8; bus.i_edge_cnt_en = 1'b0;
    bus.i_data_sample_en = 1'b1; bus.i_rx_in = 1'b0;
    tick();
    bus.i_edge_cnt_en = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (k >= 7) bus.i_rx_in = 1'b1;
      if (k == 12) bus.i_data_sample_en = 1'b0;
      if (k == 5) begin
        n_vec++;
        if (bus.o_sample_valid !== 1'b1 || bus.o_sampled_bit !== 1'b0) begin
          n_err++; $display("FAIL suppress_first_vote: got valid=%b bit=%b expected 1/0", bus.o_sample_valid, bus.o_sampled_bit);
        end
      end
      if (k >= 12) begin
        n_vec++;
        if (bus.o_sample_valid !== 1'b0 || bus.o_sampled_bit !== 1'b0) begin
          n_err++; $display("FAIL suppress_hold k=%0d: got valid=%b bit=%b expected 0/0", k, bus.o_sample_valid, bus.o_sampled_bit);
        end
      end
    end
    bus.i_edge_cnt_en = 1'b0; bus.i_data_sample_en = 1'b1;
    tick();
  endtask

  // Out-of-range prescale flags cfg_err and freezes the counters.
  task automatic test_cfg_err();
    logic [5:0] ps_tab [4];
    logic       err_tab[4];
    ps_tab  = '{6'd3, 6'd4, 6'd32, 6'd33};
    err_tab = '{1'b1, 1'b0, 1'b0, 1'b1};
    bus.i_prescale = 6'd8; bus.i_edge_cnt_en = 1'b0;
    bus.i_data_sample_en = 1'b1; bus.i_rx_in = 1'b1;
    tick();
    bus.i_prescale = 6'd2; bus.i_edge_cnt_en = 1'b1;
    tick();
    n_vec++;
    if (bus.o_cfg_err !== 1'b1) begin
      n_err++; $display("FAIL cfg_err_p2: got %b expected 1", bus.o_cfg_err);
    end
    for (int k = 0; k < 6; k++) begin
      tick();
      n_vec++;
      if (bus.o_edge_cnt !== 5'd0 || bus.o_bit_cnt !== 4'd0 || bus.o_sample_valid !== 1'b0) begin
        n_err++; $display("FAIL cfg_err_hold k=%0d: got edge=%0d bit=%0d valid=%b expected 0/0/0",
                          k, bus.o_edge_cnt, bus.o_bit_cnt, bus.o_sample_valid);
      end
    end
    bus.i_prescale = 6'd40;
    tick();
    n_vec++;
    if (bus.o_cfg_err !== 1'b1 || bus.o_edge_cnt !== 5'd0) begin
      n_err++; $display("FAIL cfg_err_p40: got err=%b edge=%0d expected 1/0", bus.o_cfg_err, bus.o_edge_cnt);
    end
    bus.i_prescale = 6'd16;
    tick();
    n_vec++;
    if (bus.o_cfg_err !== 1'b0 || bus.o_edge_cnt !== 5'd0) begin
      n_err++; $display("FAIL cfg_err_clear: got err=%b edge=%0d expected 0/0", bus.o_cfg_err, bus.o_edge_cnt);
    end
    tick();
    n_vec++;
    if (bus.o_edge_cnt !== 5'd1) begin
      n_err++; $display("FAIL cfg_err_resume: got edge=%0d expected 1", bus.o_edge_cnt);
    end
    bus.i_edge_cnt_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.i_prescale = ps_tab[i];
      tick();
      n_vec++;
      if (bus.o_cfg_err !== err_tab[i]) begin
        n_err++; $display("FAIL cfg_err_bound ps=%0d: got %b expected %b", ps_tab[i], bus.o_cfg_err, err_tab[i]);
      end
    end
    bus.i_prescale = 6'd8;
    tick();
  endtask

  // Asynchronous reset mid-frame, then bit_cnt wrap at prescale 4.
  task automatic test_reset_mid_and_wrap();
    bus.i_prescale = 6'd8; bus.i_edge_cnt_en = 1'b0;
    bus.i_data_sample_en = 1'b1; bus.i_rx_in = 1'b0;
    tick();
    bus.i_edge_cnt_en = 1'b1;
    repeat (30) tick();
    n_vec++;
    if (bus.o_edge_cnt !== 5'd6 || bus.o_bit_cnt !== 4'd3 || bus.o_sampled_bit !== 1'b0) begin
      n_err++; $display("FAIL rstmid_pre: got edge=%0d bit=%0d sbit=%b expected 6/3/0",
                        bus.o_edge_cnt, bus.o_bit_cnt, bus.o_sampled_bit);
    end
    #2 rst = 1'b0;
    #1;
    n_vec++;
    if (bus.o_edge_cnt !== 5'd0 || bus.o_bit_cnt !== 4'd0 || bus.o_sampled_bit !== 1'b1 || bus.o_sample_valid !== 1'b0) begin
      n_err++; $display("FAIL rstmid_async: got edge=%0d bit=%0d sbit=%b valid=%b expected 0/0/1/0",
                        bus.o_edge_cnt, bus.o_bit_cnt, bus.o_sampled_bit, bus.o_sample_valid);
    end
    bus.i_edge_cnt_en = 1'b0;
    #2 rst = 1'b1;
    tick();
    bus.i_prescale = 6'd4; bus.i_data_sample_en = 1'b0;
    tick();
    bus.i_edge_cnt_en = 1'b1;
    for (int k = 1; k <= 68; k++) begin
      tick();
      if (k == 60 || k == 64 || k == 68) begin
        n_vec++;
        if (bus.o_edge_cnt !== 5'd0 || bus.o_bit_cnt !== 4'((k / 4) % 16)) begin
          n_err++; $display("FAIL wrap k=%0d: got edge=%0d bit=%0d expected edge=0 bit=%0d",
                            k, bus.o_edge_cnt, bus.o_bit_cnt, (k / 4) % 16);
        end
      end
    end
    bus.i_edge_cnt_en = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_count_p8();
    test_frame_p16();
    test_glitch_p32();
    test_drop_en();
    test_suppress();
    test_cfg_err();
    test_reset_mid_and_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire
